// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked adder-subtractor: FSM states, mode encoding
// and the chunk-count helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int nch(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple stage built from 1-bit full-adder cells; also
// exposes the carry into the MSB so the caller can derive signed overflow.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    always_comb begin
        logic [1:0] fa;
        logic       carry;
        fa    = '0;
        s     = '0;
        cmsb  = cin;
        carry = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) cmsb = carry;
            fa    = full_add(a[i], b[i], carry);
            s[i]  = fa[0];
            carry = fa[1];
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle signed/unsigned adder-subtractor, CHUNK bits per clock, LSB chunk first.
// Define ADDSUB_SAT_EN to clamp overflowing results to the signed min/max.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cbi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cbo,
    output logic             ovf,
    output logic             zero
);
    import addsub_pkg::*;

    localparam int NCH = nch(WIDTH, CHUNK);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || (WIDTH % CHUNK != 0)) begin : g_cfg_check
        $error("addsub_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic             carry;
    logic [31:0]      base;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] s_c;
    logic             co;
    logic             cmsb;
    logic             ovf_next;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_final;

    // b_q already carries the subtract inversion, so the stage always adds.
    assign base = 32'(idx) * CHUNK;
    assign a_c  = a_q[base +: CHUNK];
    assign b_c  = b_q[base +: CHUNK];

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_c),
        .b    (b_c),
        .cin  (carry),
        .s    (s_c),
        .cout (co),
        .cmsb (cmsb)
    );

    assign ovf_next = cmsb ^ co;

    always_comb begin
        res_next = result;
        res_next[base +: CHUNK] = s_c;
    end

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    assign res_final = ovf_next ? (a_q[WIDTH-1] ? SMIN : SMAX) : res_next;
`else
    assign res_final = res_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cbo       <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= (sub == MODE_SUB) ? ~b : b;
                        sub_q    <= sub;
                        carry    <= (sub == MODE_ADD) ? cbi : ~cbi;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    carry <= co;
                    if (idx == LAST) begin
                        result    <= res_final;
                        cbo       <= co ^ sub_q;
                        ovf       <= ovf_next;
                        zero      <= ~|res_final;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        result <= res_next;
                        idx    <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: three builds (CHUNK 4, 1, 16) share one input stream and are
// checked every cycle against an arithmetic model of the operation and its timing.
`timescale 1ns/1ps
module tb_addsub_seq;
    localparam int W  = 16;
    localparam int NI = 3;
    localparam int NCH_I [NI] = '{4, 16, 1};

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, sub, cbi, thr_mode;
    logic [W-1:0] a, b;
    logic [NI-1:0] in_ready_w, out_valid_w, cbo_w, ovf_w, zero_w;
    logic [W-1:0] result_w [NI];

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a(a), .b(b), .sub(sub), .cbi(cbi), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .result(result_w[0]), .cbo(cbo_w[0]),
        .ovf(ovf_w[0]), .zero(zero_w[0])
    );
    addsub_seq #(.WIDTH(W), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a(a), .b(b), .sub(sub), .cbi(cbi), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .result(result_w[1]), .cbo(cbo_w[1]),
        .ovf(ovf_w[1]), .zero(zero_w[1])
    );
    addsub_seq #(.WIDTH(W), .CHUNK(16)) dut_c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .a(a), .b(b), .sub(sub), .cbi(cbi), .out_valid(out_valid_w[2]),
        .out_ready(out_ready), .result(result_w[2]), .cbo(cbo_w[2]),
        .ovf(ovf_w[2]), .zero(zero_w[2])
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic armed = 1'b0;

    logic [W+2:0] exp_q [NI][$];
    logic [W+2:0] last_out [NI];
    logic         busy_m [NI];
    logic         have_prev [NI];
    int           acc_cyc [NI];
    int           prev_acc [NI];
    int           ops_done [NI] = '{0, 0, 0};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Expected {result, cbo, ovf, zero} from integer arithmetic on the operands.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s, input logic c);
        int ux, uy, sx, sy, ci, full, sfull;
        logic [W-1:0] r;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        ci = c ? 1 : 0;
        if (s) begin
            full  = ux - uy - ci;
            sfull = sx - sy - ci;
            co    = (ux < uy + ci);
        end else begin
            full  = ux + uy + ci;
            sfull = sx + sy + ci;
            co    = (full > 65535);
        end
        r  = full[W-1:0];
        ov = (sfull > 32767) || (sfull < -32768);
`ifdef ADDSUB_SAT_EN
        if (ov) r = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {r, co, ov, (r == '0)};
    endfunction

    // Output is due once NCH+1 edges (accept edge included) have elapsed.
    function automatic logic exp_valid(input int i);
        return busy_m[i] && ((cyc - acc_cyc[i]) >= NCH_I[i] + 1);
    endfunction

    always @(posedge clk) begin
        logic [W+2:0] e;
        cyc <= cyc + 1;
        if (rst) begin
            armed <= 1'b1;
            for (int i = 0; i < NI; i++) begin
                busy_m[i]    <= 1'b0;
                have_prev[i] <= 1'b0;
                last_out[i]  <= '0;
                exp_q[i].delete();
            end
        end else if (armed) begin
            for (int i = 0; i < NI; i++) begin
                if (!busy_m[i] && in_valid) begin
                    exp_q[i].push_back(model(a, b, sub, cbi));
                    busy_m[i]  <= 1'b1;
                    acc_cyc[i] <= cyc;
                    if (thr_mode && have_prev[i])
                        check($sformatf("i%0d_throughput", i), cyc - prev_acc[i], NCH_I[i] + 2);
                    prev_acc[i]  <= cyc;
                    have_prev[i] <= thr_mode;
                end else if (exp_valid(i) && out_ready) begin
                    e = exp_q[i].pop_front();
                    last_out[i] <= e;
                    busy_m[i]   <= 1'b0;
                    ops_done[i] <= ops_done[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [W+2:0] e;
        if (armed) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("i%0d_in_ready", i), in_ready_w[i], !busy_m[i]);
                check($sformatf("i%0d_out_valid", i), out_valid_w[i], exp_valid(i));
                if (exp_valid(i) || !busy_m[i]) begin
                    e = exp_valid(i) ? exp_q[i][0] : last_out[i];
                    check($sformatf("i%0d_result", i), result_w[i], e[W+2:3]);
                    check($sformatf("i%0d_cbo", i), cbo_w[i], e[2]);
                    check($sformatf("i%0d_ovf", i), ovf_w[i], e[1]);
                    check($sformatf("i%0d_zero", i), zero_w[i], e[0]);
                end
            end
        end
    end

    function automatic logic [W-1:0] rand16();
        logic [W-1:0] corner [5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return W'($urandom_range(0, 65535));
    endfunction

    task automatic wait_idle(input string what);
        int n = 0;
        while (in_ready_w != 3'b111 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_idle_in_time", what), (n < 200), 1);
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic c);
        wait_idle("send");
        a = x; b = y; sub = s; cbi = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = rand16(); b = rand16(); sub = 1'($urandom_range(0, 1)); cbi = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic c);
        send(x, y, s, c);
        wait_idle("op");
    endtask

    initial begin
        int guard, base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; thr_mode = 1'b0;
        a = '0; b = '0; sub = 1'b0; cbi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("pin_sub_1234", model(16'h1234, 16'h0234, 1'b1, 1'b0), {16'h1000, 3'b000});
        check("pin_sub_borrow", model(16'h0000, 16'h0001, 1'b1, 1'b0), {16'hFFFF, 3'b100});
        check("pin_add_wrap", model(16'hFFFF, 16'h0001, 1'b0, 1'b0), {16'h0000, 3'b101});
        check("pin_add_ci", model(16'h00FF, 16'h0001, 1'b0, 1'b1), {16'h0101, 3'b000});
        check("pin_sub_bi", model(16'h0005, 16'h0005, 1'b1, 1'b1), {16'hFFFF, 3'b100});
        check("pin_sub_small", model(16'h0005, 16'h0003, 1'b1, 1'b0), {16'h0002, 3'b000});
`ifdef ADDSUB_SAT_EN
        check("pin_add_ovf", model(16'h7FFF, 16'h0001, 1'b0, 1'b0), {16'h7FFF, 3'b010});
        check("pin_sub_ovf", model(16'h8000, 16'h0001, 1'b1, 1'b0), {16'h8000, 3'b010});
        check("pin_sub_ovf2", model(16'h7FFF, 16'hFFFF, 1'b1, 1'b0), {16'h7FFF, 3'b110});
`else
        check("pin_add_ovf", model(16'h7FFF, 16'h0001, 1'b0, 1'b0), {16'h8000, 3'b010});
        check("pin_sub_ovf", model(16'h8000, 16'h0001, 1'b1, 1'b0), {16'h7FFF, 3'b010});
        check("pin_sub_ovf2", model(16'h7FFF, 16'hFFFF, 1'b1, 1'b0), {16'h8000, 3'b110});
`endif

        run_op(16'h1234, 16'h0234, 1'b1, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b1);
        run_op(16'h0005, 16'h0005, 1'b1, 1'b1);

        // Stall in DONE, offer a second op while busy, then release.
        out_ready = 1'b0;
        send(16'h4321, 16'h0123, 1'b0, 1'b1);
        repeat (25) @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cbi = 1'b0; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_after_release", in_ready_w, 3'b111);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle("bp");

        // Reset during the second RUN cycle, then a fresh op.
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cbi = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_run_out_valid", out_valid_w, 3'b000);
        run_op(16'h0005, 16'h0003, 1'b1, 1'b0);

        thr_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (60) begin
            a = rand16(); b = rand16(); sub = 1'($urandom_range(0, 1)); cbi = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        thr_mode = 1'b0; in_valid = 1'b0;
        wait_idle("thr");

        base  = ops_done[1];
        guard = 0;
        while ((ops_done[1] - base) < 2000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = rand16(); b = rand16(); sub = 1'($urandom_range(0, 1)); cbi = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        check("random_ops_chunk1", (ops_done[1] - base) >= 2000, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle("rand_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
